// File: rtl/des_1_to_n_align.sv
// des_1_to_n_align: 1:Ratio deserializer for Lanes lanes with manual bit-slip and pattern-based auto-alignment.
module des_1_to_n_align #(
  parameter int Ratio = 4,
  parameter int Lanes = 1,
  parameter logic [Ratio-1:0] Pattern = Ratio'((64'd1 << (Ratio / 2)) - 64'd1)
) (
  input  logic                     i_clk,
  input  logic                     i_rstb,
  input  logic                     i_en,
  input  logic [Lanes-1:0]         i_dat,
  input  logic                     i_slip,
  input  logic                     i_align_en,
  output logic [Lanes*Ratio-1:0]   o_dat,
  output logic                     o_vld,
  output logic                     o_lock,
  output logic                     o_fail
);
  localparam int CW = $clog2(Ratio);
  localparam int MW = $clog2(Ratio + 1);
  localparam logic [CW-1:0] LAST = CW'(Ratio - 1);
  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED, FAILED} state_t;
  state_t state, state_nxt;
  logic [Lanes*Ratio-1:0] sr, word;
  logic [CW-1:0] cnt;
  logic [MW-1:0] miss, miss_nxt;
  logic slip_pend, slip_nxt, act_slip, emit;
  // word is both the next shift-register value and the candidate output word
  for (genvar g = 0; g < Lanes; g++) begin : g_lane
    assign word[g*Ratio +: Ratio] = {i_dat[g], sr[g*Ratio+1 +: Ratio-1]};
  end
  assign act_slip = (state == SEARCH) ? slip_pend : i_slip;
  assign emit = i_en && !act_slip && cnt == LAST;
  assign o_lock = state == LOCKED;
  assign o_fail = state == FAILED;
  always_comb begin
    state_nxt = state;
    miss_nxt = miss;
    slip_nxt = slip_pend && !i_en;
    if (!i_align_en) begin
      state_nxt = IDLE;
      miss_nxt = '0;
      slip_nxt = 1'b0;
    end else if (state == IDLE) begin
      state_nxt = SEARCH;
      miss_nxt = '0;
      slip_nxt = 1'b0;
    end else if (state == SEARCH && o_vld) begin
      if (o_dat[Ratio-1:0] == Pattern) begin
        state_nxt = LOCKED;
      end else if (miss == MW'(Ratio - 1)) begin
        state_nxt = FAILED;
        miss_nxt = MW'(Ratio);
      end else begin
        miss_nxt = miss + MW'(1);
        slip_nxt = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      state <= IDLE;
      miss <= '0;
      slip_pend <= 1'b0;
      sr <= '0;
      cnt <= '0;
      o_dat <= '0;
      o_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      miss <= miss_nxt;
      slip_pend <= slip_nxt;
      o_vld <= emit;
      if (i_en) sr <= word;
      if (i_en && !act_slip) cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      if (emit) o_dat <= word;
    end
  end
endmodule

// File: tb/tb_des_1_to_n_align.sv
// tb_des_1_to_n_align: directed checks of deserialization, slip, gaps, alignment lock/fail and reset.
module tb_des_1_to_n_align;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstb, en, slip, align, vld, lock, fail;
  logic [0:0] dat;
  logic [3:0] odat;
  logic rstb2, en2, slip2, align2, vld2, lock2, fail2;
  logic [1:0] dat2;
  logic [7:0] odat2;
  int total = 0;
  int bad = 0;

  des_1_to_n_align dut (
    .i_clk(clk), .i_rstb(rstb), .i_en(en), .i_dat(dat), .i_slip(slip),
    .i_align_en(align), .o_dat(odat), .o_vld(vld), .o_lock(lock), .o_fail(fail)
  );

  des_1_to_n_align #(.Lanes(2)) dut2 (
    .i_clk(clk), .i_rstb(rstb2), .i_en(en2), .i_dat(dat2), .i_slip(slip2),
    .i_align_en(align2), .o_dat(odat2), .o_vld(vld2), .o_lock(lock2), .o_fail(fail2)
  );

  task automatic step(input logic e, input logic d, input logic s);
    en = e; dat = d; slip = s;
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic e, input logic [1:0] d);
    en2 = e; dat2 = d;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    align = 1'b0;
    rstb = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    rstb = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    total += 4;
    if (odat !== 4'b0) begin bad++; $display("FAIL reset_dat got=%0h want=0", odat); end
    if (vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b want=0", vld); end
    if (lock !== 1'b0) begin bad++; $display("FAIL reset_lock got=%0b want=0", lock); end
    if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%0b want=0", fail); end
  endtask

  task automatic test_basic;
    do_reset();
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL basic_early_vld got=%0b want=0", vld); end
    step(1, 1, 0);
    total += 2;
    if (vld !== 1'b1) begin bad++; $display("FAIL basic_vld got=%0b want=1", vld); end
    if (odat !== 4'b1101) begin bad++; $display("FAIL basic_dat got=%0h want=d", odat); end
    step(1, 0, 0);
    total += 2;
    if (vld !== 1'b0) begin bad++; $display("FAIL basic_vld_drop got=%0b want=0", vld); end
    if (odat !== 4'b1101) begin bad++; $display("FAIL basic_hold got=%0h want=d", odat); end
  endtask

  task automatic test_slip;
    int exp_s[4] = '{3, 8, 12, 16};
    int idx = 0;
    do_reset();
    for (int t = 0; t < 20; t++) begin
      step(1'b1, t[0], t == 7);
      if (t == 7) begin
        total++;
        if (vld !== 1'b0) begin bad++; $display("FAIL slip_no_strobe got=%0b want=0", vld); end
      end
      if (vld === 1'b1) begin
        total++;
        if (idx >= 4 || t != exp_s[idx]) begin
          bad++; $display("FAIL slip_strobe_time got=%0d want=%0d", t, (idx < 4) ? exp_s[idx] : -1);
        end
        idx++;
      end
    end
    total++;
    if (idx != 4) begin bad++; $display("FAIL slip_strobe_count got=%0d want=4", idx); end
  endtask

  task automatic test_gap;
    do_reset();
    step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0);
      total++;
      if (vld !== 1'b0) begin bad++; $display("FAIL gap_vld got=%0b want=0", vld); end
    end
    step(1, 0, 0);
    total += 2;
    if (vld !== 1'b1) begin bad++; $display("FAIL gap_end_vld got=%0b want=1", vld); end
    if (odat !== 4'b0110) begin bad++; $display("FAIL gap_dat got=%0h want=6", odat); end
  endtask

  task automatic test_lock;
    logic [3:0] p = 4'b0011;
    int lock_t = -1;
    int n = 0;
    do_reset();
    align = 1'b1;
    for (int t = 0; t < 40; t++) begin
      step(1'b1, p[(t + 1) % 4], t == 1);
      if (lock === 1'b1 && lock_t < 0) lock_t = t;
      if (lock === 1'b1 && vld === 1'b1) begin
        n++;
        total++;
        if (odat !== 4'b0011) begin bad++; $display("FAIL lock_dat got=%0h want=3", odat); end
      end
    end
    total += 4;
    if (lock_t != 19) begin bad++; $display("FAIL lock_time got=%0d want=19", lock_t); end
    if (n != 5) begin bad++; $display("FAIL lock_strobes got=%0d want=5", n); end
    if (fail !== 1'b0) begin bad++; $display("FAIL lock_no_fail got=%0b want=0", fail); end
    if (lock !== 1'b1) begin bad++; $display("FAIL lock_sticky got=%0b want=1", lock); end
    align = 1'b0;
    step(1, 0, 0);
    total++;
    if (lock !== 1'b0) begin bad++; $display("FAIL lock_drop got=%0b want=0", lock); end
  endtask

  task automatic test_fail;
    int fail_t = -1;
    int n = 0;
    do_reset();
    align = 1'b1;
    for (int t = 0; t < 40; t++) begin
      step(1, 0, 0);
      if (fail === 1'b1 && fail_t < 0) fail_t = t;
      if (fail !== 1'b1 && vld === 1'b1) n++;
    end
    total += 3;
    if (fail_t != 19) begin bad++; $display("FAIL fail_time got=%0d want=19", fail_t); end
    if (n != 4) begin bad++; $display("FAIL fail_words got=%0d want=4", n); end
    if (lock !== 1'b0) begin bad++; $display("FAIL fail_no_lock got=%0b want=0", lock); end
    align = 1'b0;
    step(1, 0, 0);
    total += 2;
    if (fail !== 1'b0) begin bad++; $display("FAIL fail_drop got=%0b want=0", fail); end
    if (lock !== 1'b0) begin bad++; $display("FAIL fail_drop_lock got=%0b want=0", lock); end
  endtask

  task automatic test_lanes;
    logic [3:0] p = 4'b0011;
    logic [3:0] q = 4'b1010;
    align2 = 1'b1;
    slip2 = 1'b0;
    rstb2 = 1'b0;
    step2(1, 2'b00);
    rstb2 = 1'b1;
    for (int t = 0; t < 10; t++) step2(1, 2'b10);
    rstb2 = 1'b0;
    step2(1, 2'b11);
    total += 4;
    if (odat2 !== 8'h00) begin bad++; $display("FAIL lanes_rst_dat got=%0h want=0", odat2); end
    if (vld2 !== 1'b0) begin bad++; $display("FAIL lanes_rst_vld got=%0b want=0", vld2); end
    if (lock2 !== 1'b0) begin bad++; $display("FAIL lanes_rst_lock got=%0b want=0", lock2); end
    if (fail2 !== 1'b0) begin bad++; $display("FAIL lanes_rst_fail got=%0b want=0", fail2); end
    rstb2 = 1'b1;
    for (int t = 0; t < 4; t++) step2(1'b1, {q[t % 4], p[t % 4]});
    total += 3;
    if (vld2 !== 1'b1) begin bad++; $display("FAIL lanes_vld got=%0b want=1", vld2); end
    if (odat2 !== 8'ha3) begin bad++; $display("FAIL lanes_dat got=%0h want=a3", odat2); end
    if (lock2 !== 1'b0) begin bad++; $display("FAIL lanes_lock_early got=%0b want=0", lock2); end
    step2(1'b1, {q[0], p[0]});
    total++;
    if (lock2 !== 1'b1) begin bad++; $display("FAIL lanes_lock got=%0b want=1", lock2); end
  endtask

  initial begin
    rstb = 1'b0; en = 1'b0; dat = 1'b0; slip = 1'b0; align = 1'b0;
    rstb2 = 1'b0; en2 = 1'b0; dat2 = 2'b00; slip2 = 1'b0; align2 = 1'b0;
    test_reset();
    test_basic();
    test_slip();
    test_gap();
    test_lock();
    test_fail();
    test_lanes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
